// File: rtl/alu_regfile_datapath_if.sv
// alu_regfile_datapath_if: register-file/ALU operand, control and result bundle
interface alu_regfile_datapath_if #(parameter int Width = 8);
    logic             reg_wr;
    logic [4:0]       RR1, RR2, WR1;
    logic [Width-1:0] WD;
    logic [1:0]       Aluop;
    logic [3:0]       func;
    logic [Width-1:0] RD1, RD2, aluOut;
    logic [3:0]       control;
    logic             carry, zero;
    modport master(output reg_wr, RR1, RR2, WR1, WD, Aluop, func,
                   input RD1, RD2, control, aluOut, carry, zero);
    modport slave(input reg_wr, RR1, RR2, WR1, WD, Aluop, func,
                  output RD1, RD2, control, aluOut, carry, zero);
endinterface

// File: rtl/alu_regfile_datapath.sv
// alu_regfile_datapath: 32-entry regfile + ALU control + ALU; REGFILE_BYPASS_EN forwards WD to same-cycle reads
module alu_regfile_datapath #(parameter int Width = 8) (
    input logic clk,
    input logic rst,
    alu_regfile_datapath_if.slave bus
);
    localparam int SW = $clog2(Width);
    logic [Width-1:0] regs_q [32];
    logic [Width-1:0] regs_d [32];
    logic             wr_en, byp1, byp2;
    logic [Width-1:0] op1, op2, res;
    logic [Width:0]   sum, diff;
    logic [SW-1:0]    shamt;
    logic [3:0]       ctl, rtype;
    logic             c;
    assign wr_en = bus.reg_wr && bus.WR1 != 5'd0;
    always_comb begin
        regs_d = regs_q;
        if (rst)
            for (int i = 0; i < 32; i++) regs_d[i] = '0;
        else if (wr_en)
            regs_d[bus.WR1] = bus.WD;
    end
    always_ff @(posedge clk) regs_q <= regs_d;
`ifdef REGFILE_BYPASS_EN
    assign byp1 = !rst && wr_en && bus.RR1 == bus.WR1;
    assign byp2 = !rst && wr_en && bus.RR2 == bus.WR1;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    assign op1 = bus.RR1 == 5'd0 ? '0 : byp1 ? bus.WD : regs_q[bus.RR1];
    assign op2 = bus.RR2 == 5'd0 ? '0 : byp2 ? bus.WD : regs_q[bus.RR2];
    always_comb begin
        case (bus.func)
            4'b1000: rtype = 4'b0110;
            4'b0001: rtype = 4'b0100;
            4'b0010: rtype = 4'b0111;
            4'b0011: rtype = 4'b1001;
            4'b0100: rtype = 4'b0011;
            4'b0101: rtype = 4'b0101;
            4'b1101: rtype = 4'b1000;
            4'b0110: rtype = 4'b0001;
            4'b0111: rtype = 4'b0000;
            default: rtype = 4'b0010;
        endcase
    end
    assign ctl = bus.Aluop == 2'b00 ? 4'b0010 :
                 bus.Aluop == 2'b01 ? 4'b0110 :
                 bus.Aluop == 2'b10 ? rtype : bus.func;
    // bit Width of the extended sum is the carry; of the extended difference, the borrow
    assign sum   = {1'b0, op1} + {1'b0, op2};
    assign diff  = {1'b0, op1} - {1'b0, op2};
    assign shamt = op2[SW-1:0];
    always_comb begin
        res = '0;
        c   = 1'b0;
        case (ctl)
            4'b0000: res = op1 & op2;
            4'b0001: res = op1 | op2;
            4'b0010: {c, res} = sum;
            4'b0011: res = op1 ^ op2;
            4'b0100: res = op1 << shamt;
            4'b0101: res = op1 >> shamt;
            4'b0110: {c, res} = diff;
            4'b0111: res = Width'($signed(op1) < $signed(op2));
            4'b1000: res = Width'($signed(op1) >>> shamt);
            4'b1001: res = Width'(op1 < op2);
            default: res = '0;
        endcase
    end
    assign bus.RD1     = op1;
    assign bus.RD2     = op2;
    assign bus.control = ctl;
    assign bus.aluOut  = res;
    assign bus.carry   = c;
    assign bus.zero    = res == '0;
endmodule

// File: tb/tb_alu_regfile_datapath.sv
// tb_alu_regfile_datapath: directed vector table plus regfile reset/write/bypass sequences
module tb_alu_regfile_datapath;
    localparam int W = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        logic [W-1:0] a, b;
        logic [1:0]   aluop;
        logic [3:0]   func;
        logic [W-1:0] out;
        logic         c, z;
        logic [3:0]   ctl;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vec_n = 0, miss_n = 0;
    vec_t v [$];
    alu_regfile_datapath_if #(.Width(W)) bus ();
    alu_regfile_datapath #(.Width(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [W-1:0] d);
        bus.reg_wr = 1'b1;
        bus.WR1 = a;
        bus.WD = d;
        tick();
        bus.reg_wr = 1'b0;
    endtask
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic [W-1:0] a, b, input logic [1:0] op, input logic [3:0] f,
                                input logic [W-1:0] o, input logic c, z, input logic [3:0] ctl);
        vec_t r;
        r.a = a; r.b = b; r.aluop = op; r.func = f; r.out = o; r.c = c; r.z = z; r.ctl = ctl;
        return r;
    endfunction
    initial begin
        v.push_back(mk(10, 4, 2'b11, 4'b0010, 14, 0, 0, 4'b0010));
        v.push_back(mk(10, 4, 2'b11, 4'b0110, 6, 0, 0, 4'b0110));
        v.push_back(mk(10, 4, 2'b11, 4'b0000, 0, 0, 1, 4'b0000));
        v.push_back(mk(10, 4, 2'b11, 4'b0001, 14, 0, 0, 4'b0001));
        v.push_back(mk(10, 4, 2'b11, 4'b0011, 14, 0, 0, 4'b0011));
        v.push_back(mk(10, 4, 2'b11, 4'b0100, 160, 0, 0, 4'b0100));
        v.push_back(mk(10, 4, 2'b11, 4'b0101, 0, 0, 1, 4'b0101));
        v.push_back(mk(10, 4, 2'b11, 4'b0111, 0, 0, 1, 4'b0111));
        v.push_back(mk(10, 4, 2'b11, 4'b1001, 0, 0, 1, 4'b1001));
        for (int f = 10; f < 16; f++) v.push_back(mk(10, 4, 2'b11, 4'(f), 0, 0, 1, 4'(f)));
        v.push_back(mk(200, 100, 2'b11, 4'b0010, 44, 1, 0, 4'b0010));
        v.push_back(mk(4, 10, 2'b11, 4'b0110, 250, 1, 0, 4'b0110));
        v.push_back(mk(8'h80, 1, 2'b11, 4'b0111, 1, 0, 0, 4'b0111));
        v.push_back(mk(8'h80, 1, 2'b11, 4'b1001, 0, 0, 1, 4'b1001));
        v.push_back(mk(8'h80, 1, 2'b11, 4'b1000, 8'hC0, 0, 0, 4'b1000));
        v.push_back(mk(8'h80, 12, 2'b11, 4'b0100, 8'h00, 0, 1, 4'b0100));
        v.push_back(mk(10, 4, 2'b00, 4'b0110, 14, 0, 0, 4'b0010));
        v.push_back(mk(10, 4, 2'b01, 4'b0000, 6, 0, 0, 4'b0110));
        v.push_back(mk(10, 4, 2'b10, 4'b1000, 6, 0, 0, 4'b0110));
        v.push_back(mk(10, 4, 2'b10, 4'b1101, 0, 0, 1, 4'b1000));
        v.push_back(mk(10, 4, 2'b10, 4'b0111, 0, 0, 1, 4'b0000));
        v.push_back(mk(10, 4, 2'b10, 4'b1111, 14, 0, 0, 4'b0010));
        v.push_back(mk(10, 4, 2'b10, 4'b0001, 160, 0, 0, 4'b0100));
        v.push_back(mk(10, 4, 2'b10, 4'b0110, 14, 0, 0, 4'b0001));
        bus.reg_wr = 1'b0; bus.RR1 = '0; bus.RR2 = '0; bus.WR1 = '0; bus.WD = '0;
        bus.Aluop = 2'b11; bus.func = 4'b0010;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.RR1 = 5'(i);
            bus.RR2 = 5'(31 - i);
            #1;
            chk($sformatf("reset RD1[%0d]", i), bus.RD1, '0);
            chk($sformatf("reset RD2[%0d]", 31 - i), bus.RD2, '0);
        end
        wr(5'd0, 8'hFF);
        bus.RR1 = 5'd0;
        #1;
        chk("reg0 write ignored", bus.RD1, '0);
        bus.RR1 = 5'd1;
        bus.RR2 = 5'd2;
        foreach (v[i]) begin
            wr(5'd1, v[i].a);
            wr(5'd2, v[i].b);
            bus.Aluop = v[i].aluop;
            bus.func = v[i].func;
            #1;
            vec_n++;
            if (bus.aluOut !== v[i].out || bus.carry !== v[i].c || bus.zero !== v[i].z || bus.control !== v[i].ctl) begin
                miss_n++;
                $display("FAIL vec%0d aluop=%b func=%b: got out=%0d c=%b z=%b ctl=%b expected out=%0d c=%b z=%b ctl=%b",
                         i, v[i].aluop, v[i].func, bus.aluOut, bus.carry, bus.zero, bus.control,
                         v[i].out, v[i].c, v[i].z, v[i].ctl);
            end
        end
        wr(5'd3, 5);
        bus.RR1 = 5'd3;
        bus.reg_wr = 1'b1;
        bus.WR1 = 5'd3;
        bus.WD = 9;
        #1;
        chk("reg3 same-cycle read", bus.RD1, BYP ? 8'd9 : 8'd5);
        tick();
        bus.reg_wr = 1'b0;
        chk("reg3 after edge", bus.RD1, 9);
        rst = 1'b1;
        bus.reg_wr = 1'b1;
        bus.WD = 7;
        #1;
        chk("reg3 bypass off in reset", bus.RD1, 9);
        tick();
        rst = 1'b0;
        bus.reg_wr = 1'b0;
        #1;
        chk("reg3 reset beats write", bus.RD1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end
endmodule

// File: doc/alu_regfile_datapath.md
Name: alu_regfile_datapath

Overview:
- Execute-stage datapath slice for the RISC-V core: a 32-entry register file feeding a combinational ALU through an ALU-control decoder.
- Two operands are read combinationally, and the ALU operation is selected from Aluop/func.
- One register write per clock.

Parameters:
- Width, 8, data width of registers, ALU operands and result. Must be a power of two, 4..64.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- reg_wr  input  1  register write enable
- RR1  input  5  read address, port 1 (operand op1)
- RR2  input  5  read address, port 2 (operand op2)
- WR1  input  5  write address
- WD  input  Width  write data
- Aluop  input  2  ALU operation class from main control
- func  input  4  function field {funct7[5], funct3}, or a direct control code
- RD1  output  Width  read data, port 1
- RD2  output  Width  read data, port 2
- control  output  4  decoded ALU control code
- aluOut  output  Width  ALU result of op(RD1, RD2)
- carry  output  1  carry/borrow flag
- zero  output  1  1 when aluOut == 0

Behaviour:
- Register file:
  - 32 x Width storage.
  - Reads are combinational.
  - Write occurs at posedge clk when reg_wr=1 and WR1!=0.
  - Register 0 is hardwired to 0: writes are ignored, reads return 0.
- Reset:
  - rst=1 at posedge clears all 32 registers to 0.
  - rst has priority over a simultaneous write.
  - Reset mid-operation discards any pending write.
- Read during write to the same address: returns the old value until the edge (no bypass; see optional feature).
- Control codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SRA, 1001 SLTU.
  - Codes 1010-1111 give aluOut=0, carry=0.
- ALU-control decode (combinational):
  - Aluop=00 → ADD.
  - Aluop=01 → SUB.
  - Aluop=10 (R-type), func → control:
    - 0000→ADD, 1000→SUB, 0001→SLL, 0010→SLT, 0011→SLTU
    - 0100→XOR, 0101→SRL, 1101→SRA, 0110→OR, 0111→AND
    - other func → ADD
  - Aluop=11 (direct): control = func unchanged.
- ALU (combinational, zero latency):
  - ADD: aluOut = low Width bits of op1+op2; carry = bit Width of the sum.
  - SUB: aluOut = op1-op2 mod 2^Width; carry = borrow, i.e. 1 iff op1 < op2 unsigned.
  - SLT: aluOut = 1 if op1 < op2 signed, else 0.
  - SLTU: aluOut = 1 if op1 < op2 unsigned, else 0.
  - Shifts: amount = op2[$clog2(Width)-1:0]; upper op2 bits ignored. SRA fills with op1[Width-1].
  - carry = 0 for all operations except ADD and SUB.
  - zero = (aluOut == 0) for every code, including undefined ones.
- No X on outputs after the first reset; before the first reset, register contents are undefined.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when reg_wr=1, WR1!=0, and RR1 (or RR2) == WR1 in the same cycle, the matching RD output returns WD combinationally. The ALU therefore sees the new value before the edge.
- Bypass is suppressed while rst=1.
- Undefined: plain read-old-value behaviour as above.

Test Plan:
- Reset, then read all 32 addresses → RD1/RD2 = 0. Write reg0 = 8'hFF → RD1 (RR1=0) stays 0.
- Write reg1=10, reg2=4; RR1=1, RR2=2, Aluop=11:
  - func=0010 → aluOut=14, carry=0, zero=0
  - func=0110 → 6, carry=0
  - func=0000 → 0, zero=1
  - func=0001 → 14
  - func=0011 → 14
- Same operands, direct-mode shifts and compares:
  - func=0100 → 160
  - func=0101 → 0
  - func=0111 → 0
  - func=1001 → 0
  - func=1010..1111 → aluOut=0, zero=1, carry=0
- Carry/borrow and signed compares:
  - reg1=200, reg2=100, ADD → 44, carry=1
  - reg1=4, reg2=10, SUB → 250, carry=1
  - reg1=8'h80, reg2=1: SLT → 1; SLTU → 0; SRA → 8'hC0
- Decode check:
  - Aluop=00 → control=0010; Aluop=01 → 0110
  - Aluop=10 with func=1000/1101/0111/1111 → 0110/1000/0000/0010
- Same-cycle write+read of reg3 (old 5, WD=9):
  - Before the edge, RD1 = 5 (9 with REGFILE_BYPASS_EN); after the edge, 9.
  - rst=1 together with reg_wr=1 → reg3 = 0 after the edge.
